// File: rtl/dma_req_arbiter.sv
// Two-requester DMA arbiter: round-robin per beat, locked for write bursts,
// with an owner FIFO that routes response beats back to the issuing requester.
module dma_req_arbiter #(
    parameter int abits      = 24,
    parameter int log2_depth = 2
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,

    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [1:0]            i_req_write,
    input  logic [1:0]            i_req_last,
    input  logic [1:0][11:0]      i_req_bytes,
    input  logic [1:0][abits-1:0] i_req_addr,
    input  logic [1:0][7:0]       i_req_strob,
    input  logic [1:0][63:0]      i_req_data,

    output logic [1:0]            o_resp_valid,
    output logic [1:0]            o_resp_last,
    output logic [1:0]            o_resp_fault,
    output logic [abits-1:0]      o_resp_addr,
    output logic [63:0]           o_resp_data,
    input  logic [1:0]            i_resp_ready,

    output logic                  o_req_mem_valid,
    output logic                  o_req_mem_write,
    output logic                  o_req_mem_last,
    output logic [11:0]           o_req_mem_bytes,
    output logic [abits-1:0]      o_req_mem_addr,
    output logic [7:0]            o_req_mem_strob,
    output logic [63:0]           o_req_mem_data,
    input  logic                  i_req_mem_ready,

    input  logic                  i_resp_mem_valid,
    input  logic                  i_resp_mem_last,
    input  logic                  i_resp_mem_fault,
    input  logic [abits-1:0]      i_resp_mem_addr,
    input  logic [63:0]           i_resp_mem_data,
    output logic                  o_resp_mem_ready,

    output logic                  o_orphan_resp
);

    localparam int DEPTH = 1 << log2_depth;
    localparam logic [log2_depth:0] FULL_CNT = {1'b1, {log2_depth{1'b0}}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rr;
    logic                  w_rr_nxt;
    logic                  r_lock;
    logic                  w_lock_nxt;
    logic [log2_depth-1:0] r_wr_ptr;
    logic [log2_depth-1:0] r_rd_ptr;
    logic [log2_depth:0]   r_count;
    logic [DEPTH-1:0]      r_owner;
    logic                  r_orphan;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_grant;
    logic                  w_fwd_en;
    logic                  w_req_hs;
    logic                  w_push;
    logic                  w_head;
    logic                  w_resp_hs;
    logic                  w_pop;
    logic                  w_orphan_set;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Grant selection: a burst owner is forwarded even when the FIFO is full,
    // because its single FIFO entry was already pushed on the first beat.
    always_comb begin
        w_grant  = r_rr;
        w_fwd_en = 1'b0;
        o_req_mem_valid = 1'b0;
        if (r_state == S_BURST) begin
            w_grant         = r_lock;
            w_fwd_en        = 1'b1;
            o_req_mem_valid = i_req_valid[r_lock];
        end else begin
            w_grant         = i_req_valid[r_rr] ? r_rr : ~r_rr;
            w_fwd_en        = (|i_req_valid) & ~w_full;
            o_req_mem_valid = w_fwd_en;
        end
    end

    always_comb begin
        o_req_ready          = '0;
        o_req_ready[w_grant] = w_fwd_en & i_req_mem_ready;
    end

    assign o_req_mem_write = i_req_write[w_grant];
    assign o_req_mem_last  = i_req_last[w_grant];
    assign o_req_mem_bytes = i_req_bytes[w_grant];
    assign o_req_mem_addr  = i_req_addr[w_grant];
    assign o_req_mem_strob = i_req_strob[w_grant];
    assign o_req_mem_data  = i_req_data[w_grant];

    assign w_req_hs = o_req_mem_valid & i_req_mem_ready;
    assign w_push   = (r_state == S_IDLE) & w_req_hs;

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_lock_nxt  = r_lock;
        case (r_state)
            S_IDLE: begin
                if (w_push) begin
                    w_rr_nxt = ~w_grant;
                    if (i_req_write[w_grant] && !i_req_last[w_grant]) begin
                        w_state_nxt = S_BURST;
                        w_lock_nxt  = w_grant;
                    end
                end
            end
            S_BURST: begin
                if (w_req_hs && i_req_last[r_lock]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Response routing follows the oldest outstanding owner; with nothing
    // outstanding, beats are drained and flagged as orphans.
    assign w_head = r_owner[r_rd_ptr];

    always_comb begin
        o_resp_valid     = '0;
        o_resp_mem_ready = 1'b1;
        if (!w_empty) begin
            o_resp_valid[w_head] = i_resp_mem_valid;
            o_resp_mem_ready     = i_resp_ready[w_head];
        end
    end

    assign o_resp_last  = {2{i_resp_mem_last}};
    assign o_resp_fault = {2{i_resp_mem_fault}};
    assign o_resp_addr  = i_resp_mem_addr;
    assign o_resp_data  = i_resp_mem_data;

    assign w_resp_hs    = i_resp_mem_valid & o_resp_mem_ready;
    assign w_pop        = ~w_empty & w_resp_hs & i_resp_mem_last;
    assign w_orphan_set = w_empty & w_resp_hs;
    assign o_orphan_resp = r_orphan;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state  <= S_IDLE;
            r_rr     <= 1'b0;
            r_lock   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_orphan <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_lock  <= w_lock_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_orphan_set) begin
                r_orphan <= 1'b1;
            end
        end
    end

    // Owner storage is only meaningful below r_count, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_owner[r_wr_ptr] <= w_grant;
        end
    end

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Bench for dma_req_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of arbitration and response routing.
module tb_dma_req_arbiter;

    localparam int AB    = 24;
    localparam int LD    = 2;
    localparam int DEPTH = 4;

    logic                 i_clk = 1'b0;
    logic                 i_nrst;
    logic [1:0]           i_req_valid;
    logic [1:0]           o_req_ready;
    logic [1:0]           i_req_write;
    logic [1:0]           i_req_last;
    logic [1:0][11:0]     i_req_bytes;
    logic [1:0][AB-1:0]   i_req_addr;
    logic [1:0][7:0]      i_req_strob;
    logic [1:0][63:0]     i_req_data;
    logic [1:0]           o_resp_valid;
    logic [1:0]           o_resp_last;
    logic [1:0]           o_resp_fault;
    logic [AB-1:0]        o_resp_addr;
    logic [63:0]          o_resp_data;
    logic [1:0]           i_resp_ready;
    logic                 o_req_mem_valid;
    logic                 o_req_mem_write;
    logic                 o_req_mem_last;
    logic [11:0]          o_req_mem_bytes;
    logic [AB-1:0]        o_req_mem_addr;
    logic [7:0]           o_req_mem_strob;
    logic [63:0]          o_req_mem_data;
    logic                 i_req_mem_ready;
    logic                 i_resp_mem_valid;
    logic                 i_resp_mem_last;
    logic                 i_resp_mem_fault;
    logic [AB-1:0]        i_resp_mem_addr;
    logic [63:0]          i_resp_mem_data;
    logic                 o_resp_mem_ready;
    logic                 o_orphan_resp;

    int errors = 0;
    int checks = 0;

    int   m_q[$];
    bit   m_rr, m_burst, m_lock, m_orphan;
    bit   e_mv, e_g, e_rmr;
    bit [1:0] e_rdy, e_rv;

    always #5 i_clk = ~i_clk;

    dma_req_arbiter #(.abits(AB), .log2_depth(LD)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_last(i_req_last),
        .i_req_bytes(i_req_bytes), .i_req_addr(i_req_addr),
        .i_req_strob(i_req_strob), .i_req_data(i_req_data),
        .o_resp_valid(o_resp_valid), .o_resp_last(o_resp_last),
        .o_resp_fault(o_resp_fault), .o_resp_addr(o_resp_addr),
        .o_resp_data(o_resp_data), .i_resp_ready(i_resp_ready),
        .o_req_mem_valid(o_req_mem_valid), .o_req_mem_write(o_req_mem_write),
        .o_req_mem_last(o_req_mem_last), .o_req_mem_bytes(o_req_mem_bytes),
        .o_req_mem_addr(o_req_mem_addr), .o_req_mem_strob(o_req_mem_strob),
        .o_req_mem_data(o_req_mem_data), .i_req_mem_ready(i_req_mem_ready),
        .i_resp_mem_valid(i_resp_mem_valid), .i_resp_mem_last(i_resp_mem_last),
        .i_resp_mem_fault(i_resp_mem_fault), .i_resp_mem_addr(i_resp_mem_addr),
        .i_resp_mem_data(i_resp_mem_data), .o_resp_mem_ready(o_resp_mem_ready),
        .o_orphan_resp(o_orphan_resp)
    );

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        i_req_valid      = '0;
        i_req_write      = '0;
        i_req_last       = '0;
        i_req_bytes      = '0;
        i_req_addr       = '0;
        i_req_strob      = '0;
        i_req_data       = '0;
        i_resp_ready     = '0;
        i_req_mem_ready  = 1'b0;
        i_resp_mem_valid = 1'b0;
        i_resp_mem_last  = 1'b0;
        i_resp_mem_fault = 1'b0;
        i_resp_mem_addr  = '0;
        i_resp_mem_data  = '0;
    endtask

    task automatic do_reset();
        i_nrst = 1'b0;
        idle_inputs();
        repeat (2) cyc();
        i_nrst = 1'b1;
        cyc();
    endtask

    // Reference model: owner queue, round-robin pointer and burst lock.
    task automatic model_reset();
        m_q.delete();
        m_rr = 0; m_burst = 0; m_lock = 0; m_orphan = 0;
    endtask

    task automatic model_eval();
        e_rdy = '0; e_rv = '0; e_mv = 0; e_g = m_rr; e_rmr = 1;
        if (m_burst) begin
            e_g = m_lock;
            e_mv = i_req_valid[m_lock];
            e_rdy[m_lock] = i_req_mem_ready;
        end else if (i_req_valid != 2'b00 && m_q.size() < DEPTH) begin
            e_g = i_req_valid[m_rr] ? m_rr : !m_rr;
            e_mv = 1;
            e_rdy[e_g] = i_req_mem_ready;
        end
        if (m_q.size() != 0) begin
            e_rv[m_q[0]] = i_resp_mem_valid;
            e_rmr = i_resp_ready[m_q[0]];
        end
    endtask

    task automatic model_commit();
        bit do_pop;
        do_pop = (m_q.size() > 0) && i_resp_mem_valid && e_rmr && i_resp_mem_last;
        if (m_q.size() == 0 && i_resp_mem_valid) m_orphan = 1;
        if (e_mv && i_req_mem_ready) begin
            if (!m_burst) begin
                m_q.push_back(int'(e_g));
                m_rr = !e_g;
                if (i_req_write[e_g] && !i_req_last[e_g]) begin
                    m_burst = 1;
                    m_lock = e_g;
                end
            end else if (i_req_last[e_g]) begin
                m_burst = 0;
            end
        end
        if (do_pop) void'(m_q.pop_front());
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if ({o_req_mem_valid, o_req_ready, o_resp_valid, o_resp_mem_ready, o_orphan_resp} !== 7'b0000010) begin
            errors++;
            $display("FAIL reset_during: got %b want 0000010",
                     {o_req_mem_valid, o_req_ready, o_resp_valid, o_resp_mem_ready, o_orphan_resp});
        end
        cyc();
        i_nrst = 1'b1;
        cyc();
        settle();
        checks++;
        if ({o_req_mem_valid, o_req_ready, o_resp_valid, o_resp_mem_ready, o_orphan_resp} !== 7'b0000010) begin
            errors++;
            $display("FAIL reset_after: got %b want 0000010",
                     {o_req_mem_valid, o_req_ready, o_resp_valid, o_resp_mem_ready, o_orphan_resp});
        end
    endtask

    task automatic test_alternate();
        logic [1:0] want;
        do_reset();
        i_req_valid = 2'b11;
        i_req_addr[0] = 24'h000100;
        i_req_addr[1] = 24'h000200;
        i_req_mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            want = (i % 2 == 1) ? 2'b10 : 2'b01;
            checks++;
            if (o_req_ready !== want || o_req_mem_addr !== i_req_addr[i % 2]) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got ready=%b addr=%h want ready=%b addr=%h",
                         i, o_req_ready, o_req_mem_addr, want, i_req_addr[i % 2]);
            end
            cyc();
        end
        settle();
        checks++;
        if (o_req_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_full: got mem_valid=%b want 0", o_req_mem_valid);
        end
        cyc();
        i_req_valid = 2'b00;
        i_resp_ready = 2'b11;
        i_resp_mem_valid = 1'b1;
        i_resp_mem_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            want = (i % 2 == 1) ? 2'b10 : 2'b01;
            checks++;
            if (o_resp_valid !== want) begin
                errors++;
                $display("FAIL alt_resp[%0d]: got %b want %b", i, o_resp_valid, want);
            end
            cyc();
        end
        i_resp_mem_valid = 1'b0;
    endtask

    task automatic test_burst();
        do_reset();
        i_req_mem_ready = 1'b1;
        i_req_valid = 2'b01;
        settle();
        cyc();
        i_req_valid = 2'b11;
        i_req_write = 2'b10;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                i_req_valid[1] = 1'b0;
                settle();
                checks++;
                if (o_req_mem_valid !== 1'b0 || o_req_ready[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_drop: got mem_valid=%b ready=%b want valid=0 ready0=0",
                             o_req_mem_valid, o_req_ready);
                end
                cyc();
                i_req_valid[1] = 1'b1;
            end
            i_req_last[1] = (b == 3);
            settle();
            checks++;
            if (o_req_ready !== 2'b10 || o_req_mem_write !== 1'b1 || o_req_mem_last !== (b == 3)) begin
                errors++;
                $display("FAIL burst_beat[%0d]: got ready=%b wr=%b last=%b want ready=10 wr=1 last=%0d",
                         b, o_req_ready, o_req_mem_write, o_req_mem_last, (b == 3));
            end
            cyc();
        end
        i_req_write = 2'b00;
        i_req_last = 2'b00;
        settle();
        checks++;
        if (o_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL burst_after: got %b want 01", o_req_ready);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        int acc;
        do_reset();
        acc = 0;
        i_req_valid = 2'b01;
        i_req_mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (o_req_ready[0]) acc++;
            if (i >= 4) begin
                checks++;
                if (o_req_mem_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL full_block[%0d]: got mem_valid=%b want 0", i, o_req_mem_valid);
                end
            end
            cyc();
        end
        checks++;
        if (acc != 4) begin
            errors++;
            $display("FAIL full_accepted: got %0d want 4", acc);
        end
        i_resp_mem_valid = 1'b1;
        i_resp_mem_last = 1'b1;
        i_resp_ready = 2'b01;
        settle();
        checks++;
        if (o_req_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_cycle: got mem_valid=%b want 0", o_req_mem_valid);
        end
        cyc();
        i_resp_mem_valid = 1'b0;
        settle();
        checks++;
        if (o_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL full_one_more: got %b want 01", o_req_ready);
        end
        cyc();
        settle();
        checks++;
        if (o_req_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_again: got mem_valid=%b want 0", o_req_mem_valid);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_resp_beats();
        do_reset();
        i_req_valid = 2'b01;
        i_req_mem_ready = 1'b1;
        settle();
        cyc();
        i_req_valid = 2'b00;
        i_resp_mem_valid = 1'b1;
        i_resp_mem_last = 1'b0;
        i_resp_mem_fault = 1'b1;
        i_resp_mem_addr = 24'hABCDEF;
        i_resp_mem_data = 64'h0123_4567_89AB_CDEF;
        i_resp_ready = 2'b01;
        settle();
        checks++;
        if (o_resp_valid !== 2'b01 || o_resp_mem_ready !== 1'b1 || o_resp_addr !== 24'hABCDEF ||
            o_resp_data !== 64'h0123_4567_89AB_CDEF || o_resp_fault[0] !== 1'b1 || o_resp_last[0] !== 1'b0) begin
            errors++;
            $display("FAIL resp_beat1: got v=%b rdy=%b a=%h d=%h f=%b l=%b want v=01 rdy=1 a=abcdef d=0123456789abcdef f=1 l=0",
                     o_resp_valid, o_resp_mem_ready, o_resp_addr, o_resp_data, o_resp_fault[0], o_resp_last[0]);
        end
        cyc();
        i_resp_mem_last = 1'b1;
        i_resp_mem_fault = 1'b0;
        i_resp_ready = 2'b00;
        settle();
        checks++;
        if (o_resp_valid !== 2'b01 || o_resp_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL resp_stall: got v=%b rdy=%b want v=01 rdy=0", o_resp_valid, o_resp_mem_ready);
        end
        cyc();
        i_resp_ready = 2'b01;
        settle();
        checks++;
        if (o_resp_valid !== 2'b01 || o_resp_mem_ready !== 1'b1 || o_resp_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL resp_beat2: got v=%b rdy=%b l=%b want v=01 rdy=1 l=1",
                     o_resp_valid, o_resp_mem_ready, o_resp_last[0]);
        end
        cyc();
        settle();
        checks++;
        if (o_resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL resp_popped: got v=%b want 00", o_resp_valid);
        end
        i_resp_mem_valid = 1'b0;
        cyc();
        settle();
        checks++;
        if (o_orphan_resp !== 1'b0) begin
            errors++;
            $display("FAIL resp_no_orphan: got %b want 0", o_orphan_resp);
        end
        idle_inputs();
    endtask

    task automatic test_orphan();
        do_reset();
        i_resp_mem_valid = 1'b1;
        i_resp_mem_last = 1'b1;
        i_resp_ready = 2'b00;
        settle();
        checks++;
        if (o_resp_mem_ready !== 1'b1 || o_resp_valid !== 2'b00 || o_orphan_resp !== 1'b0) begin
            errors++;
            $display("FAIL orphan_drain: got rdy=%b v=%b orphan=%b want rdy=1 v=00 orphan=0",
                     o_resp_mem_ready, o_resp_valid, o_orphan_resp);
        end
        cyc();
        i_resp_mem_valid = 1'b0;
        settle();
        checks++;
        if (o_orphan_resp !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set: got %b want 1", o_orphan_resp);
        end
        repeat (3) cyc();
        settle();
        checks++;
        if (o_orphan_resp !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky: got %b want 1", o_orphan_resp);
        end
        i_nrst = 1'b0;
        #1;
        checks++;
        if (o_orphan_resp !== 1'b0) begin
            errors++;
            $display("FAIL orphan_async_clear: got %b want 0", o_orphan_resp);
        end
        cyc();
        i_nrst = 1'b1;
        cyc();
    endtask

    task automatic test_reset_midburst();
        do_reset();
        i_req_mem_ready = 1'b1;
        i_req_valid = 2'b10;
        cyc();
        i_req_valid = 2'b01;
        cyc();
        i_req_write = 2'b01;
        i_req_last = 2'b00;
        settle();
        checks++;
        if (o_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midburst_start: got %b want 01", o_req_ready);
        end
        cyc();
        i_nrst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({o_req_mem_valid, o_req_ready, o_resp_valid, o_resp_mem_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL midburst_in_reset: got %b want 000001",
                     {o_req_mem_valid, o_req_ready, o_resp_valid, o_resp_mem_ready});
        end
        cyc();
        i_nrst = 1'b1;
        cyc();
        i_req_valid = 2'b11;
        i_req_mem_ready = 1'b1;
        settle();
        checks++;
        if (o_req_ready !== 2'b01 || o_resp_mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL midburst_rr: got ready=%b resp_rdy=%b want 01 1", o_req_ready, o_resp_mem_ready);
        end
        cyc();
        settle();
        checks++;
        if (o_req_ready !== 2'b10) begin
            errors++;
            $display("FAIL midburst_idle: got %b want 10", o_req_ready);
        end
        cyc();
        cyc();
        settle();
        checks++;
        if (o_req_mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL midburst_count4: got mem_valid=%b want 1", o_req_mem_valid);
        end
        cyc();
        settle();
        checks++;
        if (o_req_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL midburst_count_full: got mem_valid=%b want 0", o_req_mem_valid);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int n = 0; n < 800; n++) begin
            for (int r = 0; r < 2; r++) begin
                i_req_valid[r] = ($urandom_range(0, 2) != 0);
                i_req_write[r] = $urandom_range(0, 1);
                i_req_last[r]  = ($urandom_range(0, 2) == 0);
                i_req_bytes[r] = 12'($urandom);
                i_req_addr[r]  = 24'($urandom);
                i_req_strob[r] = 8'($urandom);
                i_req_data[r]  = {$urandom, $urandom};
            end
            i_req_mem_ready  = ($urandom_range(0, 3) != 0);
            i_resp_mem_valid = (n > 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            i_resp_mem_last  = $urandom_range(0, 1);
            i_resp_ready     = 2'($urandom);
            i_resp_mem_addr  = 24'($urandom);
            i_resp_mem_data  = {$urandom, $urandom};
            settle();
            model_eval();
            checks++;
            if (o_req_mem_valid !== e_mv || o_req_ready !== e_rdy) begin
                errors++;
                $display("FAIL rnd_req[%0d]: got v=%b rdy=%b want v=%b rdy=%b", n,
                         o_req_mem_valid, o_req_ready, e_mv, e_rdy);
            end
            if (e_mv) begin
                checks++;
                if (o_req_mem_addr !== i_req_addr[e_g] || o_req_mem_data !== i_req_data[e_g] ||
                    o_req_mem_bytes !== i_req_bytes[e_g] || o_req_mem_strob !== i_req_strob[e_g]) begin
                    errors++;
                    $display("FAIL rnd_fields[%0d]: got a=%h d=%h want a=%h d=%h", n,
                             o_req_mem_addr, o_req_mem_data, i_req_addr[e_g], i_req_data[e_g]);
                end
            end
            checks++;
            if (o_resp_valid !== e_rv || o_resp_mem_ready !== e_rmr || o_orphan_resp !== m_orphan) begin
                errors++;
                $display("FAIL rnd_resp[%0d]: got v=%b rdy=%b orphan=%b want v=%b rdy=%b orphan=%b", n,
                         o_resp_valid, o_resp_mem_ready, o_orphan_resp, e_rv, e_rmr, m_orphan);
            end
            model_commit();
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alternate();
        test_burst();
        test_fifo_full();
        test_resp_beats();
        test_orphan();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_req_arbiter.md
DMA_REQ_ARBITER -- requirements
Module: dma_req_arbiter

Interface
REQ-001 Parameter abits, default 24, sets the framebuffer byte-address width of the request and response address buses.
REQ-002 Parameter log2_depth, default 2, sets the outstanding-transaction owner FIFO depth to 2**log2_depth.
REQ-003 i_clk  in  1  single clock for all logic.
REQ-004 i_nrst  in  1  reset, asynchronous, active-low.
REQ-005 i_req_valid  in  2  per-requester request valid; requester 0 is the display framebuffer, requester 1 is the 2D engine.
REQ-006 o_req_ready  out  2  per-requester request accepted.
REQ-007 i_req_write, i_req_last  in  2 each  per-requester operation (0=read) and last beat of a write burst.
REQ-008 i_req_bytes  in  2x12; i_req_addr  in  2xabits; i_req_strob  in  2x8; i_req_data  in  2x64  per-requester request fields.
REQ-009 o_resp_valid, o_resp_last, o_resp_fault  out  2 each  per-requester response handshake and status.
REQ-010 o_resp_addr  out  abits; o_resp_data  out  64  response payload, broadcast to both requesters.
REQ-011 i_resp_ready  in  2  per-requester response ready.
REQ-012 Downstream DMA port: o_req_mem_valid/write/last out 1, o_req_mem_bytes out 12, o_req_mem_addr out abits, o_req_mem_strob out 8, o_req_mem_data out 64, i_req_mem_ready in 1; i_resp_mem_valid/last/fault in 1, i_resp_mem_addr in abits, i_resp_mem_data in 64, o_resp_mem_ready out 1.
REQ-013 o_orphan_resp  out  1  sticky error: response beat arrived with no outstanding transaction.

Function
REQ-014 A transaction SHALL be one read beat, or the write beats up to and including the beat with i_req_last=1.
REQ-015 States: IDLE (arbitrate per beat) and BURST (locked to owner until write last beat).
REQ-016 In IDLE with owner FIFO not full, the granted requester SHALL be the valid requester with priority pointer rr; otherwise the other valid one.
REQ-017 In IDLE with FIFO full (count==2**log2_depth), o_req_mem_valid and o_req_ready SHALL be 0.
REQ-018 Request path SHALL be combinational, zero latency: granted requester fields drive downstream; o_req_ready[g]=i_req_mem_ready, non-granted ready=0.
REQ-019 On IDLE handshake: push owner id g into FIFO; rr <= ~g; if write and !last, go to BURST with lock=g.
REQ-020 In BURST, only requester lock SHALL be forwarded, regardless of FIFO full; other requester ready=0; accepted beat with last=1 returns to IDLE; no push in BURST.
REQ-021 Response routing: while FIFO non-empty, o_resp_valid[head]=i_resp_mem_valid, other=0; o_resp_mem_ready=i_resp_ready[head].
REQ-022 Pop SHALL occur on i_resp_mem_valid & o_resp_mem_ready & i_resp_mem_last.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; pointers wrap modulo depth.
REQ-024 With FIFO empty: o_resp_valid=0, o_resp_mem_ready=1 (drain), and any accepted beat SHALL set o_orphan_resp until reset.
REQ-025 o_resp_last, o_resp_fault, o_resp_addr, o_resp_data SHALL pass i_resp_mem_* unchanged.
REQ-026 Requester dropping valid mid-BURST SHALL keep the lock; downstream valid follows requester valid.

Reset
REQ-027 On i_nrst=0 immediately: state IDLE, rr=0, lock=0, rd/wr pointers=0, count=0, o_orphan_resp=0.
REQ-028 During and after reset with inputs idle, all valid/ready outputs SHALL be 0 except o_resp_mem_ready=1.
REQ-029 Reset mid-burst or with outstanding transactions SHALL discard all ownership state.

Verification
REQ-030 Both requesters continuously issue reads, ready=1 -> grants alternate 0,1,0,1; FIFO order matches; responses routed to 0,1,0,1.
REQ-031 Requester 1 writes 4-beat burst (last on beat 4) while requester 0 valid -> four consecutive grants to 1, then 0 granted next cycle.
REQ-032 Six reads with no responses, depth 4 -> exactly four accepted, o_req_mem_valid=0 after; one last response -> one more accepted.
REQ-033 Response beat with last=0 then last=1 for owner 0 -> both routed to requester 0, pop only on second; requester 0 ready=0 stalls o_resp_mem_ready.
REQ-034 Response with FIFO empty -> o_resp_mem_ready=1, no o_resp_valid, o_orphan_resp=1 until i_nrst low.
REQ-035 Assert i_nrst=0 in BURST with 3 outstanding -> next cycle after release state IDLE, count=0, rr=0.
